// File: rtl/im_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// Holds the loader state encoding, frame geometry and the RxReady/CpuHold decode.
package im_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR_HI,
        HDR_LO,
        PAYLOAD,
        WRITE,
        CHK,
        DONE,
        ERR
    } loaderState_e;

    localparam int HDR_BYTES           = 2;
    localparam int WORD_BYTES          = 4;
    localparam int DEFAULT_DEPTH_WORDS = 128;

    // Bytes are taken only while a frame field is being collected.
    function automatic logic rxReadyFor(input loaderState_e s);
        case (s)
            HDR_HI, HDR_LO, PAYLOAD, CHK: rxReadyFor = 1'b1;
            default:                      rxReadyFor = 1'b0;
        endcase
    endfunction

    // The CPU stays held for a whole load and after a failed one.
    function automatic logic cpuHoldFor(input loaderState_e s);
        case (s)
            IDLE, DONE: cpuHoldFor = 1'b0;
            default:    cpuHoldFor = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/im_word_assembler.sv
// Collects bytes into a big-endian 32-bit word and flags the byte that completes it.
// The first byte of a word ends up in [31:24] after four shifts.
module im_word_assembler
    import im_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        byteValid_i,
    input  logic [7:0]  rxByte_i,
    output logic [31:0] word_o,
    output logic        wordFull_o
);

    localparam int                      CNT_W     = $clog2(WORD_BYTES);
    localparam logic [CNT_W-1:0]        LAST_BYTE = CNT_W'(WORD_BYTES - 1);

    logic [31:0]      word_q, word_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The counter wraps naturally after the last byte, so the next word starts clean.
    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            word_d = '0;
            cnt_d  = '0;
        end else if (byteValid_i) begin
            word_d = {word_q[23:0], rxByte_i};
            cnt_d  = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign word_o     = word_q;
    assign wordFull_o = byteValid_i && (cnt_q == LAST_BYTE);

endmodule

// File: rtl/im_program_loader.sv
// Boot loader: parses a framed byte stream and writes big-endian words into the IM.
// Frame = 16-bit word count, 4*N payload bytes, XOR checksum of all prior bytes.
module im_program_loader
    import im_loader_pkg::*;
#(
    parameter int          DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [7:0]  RxData,
    input  logic        RxValid,
    output logic        RxReady,
    output logic        ImWrEn,
    output logic [31:0] ImWrAddr,
    output logic [31:0] ImWrData,
    output logic        CpuHold,
    output logic        Done,
    output logic        Error
);

    loaderState_e state_q, state_d;
    logic [15:0]  nWords_q, nWords_d;
    logic [15:0]  wordCnt_q, wordCnt_d;
    logic [7:0]   xor_q, xor_d;
    logic [31:0]  addr_q, addr_d;

    logic         accept;
    logic         enterHdr;
    logic         payloadByte;
    logic         wordFull;
    logic [15:0]  headerN;
    logic [31:0]  asmWord;

    assign accept      = RxValid && RxReady;
    assign payloadByte = accept && (state_q == PAYLOAD);
    assign headerN     = {nWords_q[15:8], RxData};

    im_word_assembler u_assembler (
        .clk_i       (Clk),
        .rst_i       (Rst),
        .clear_i     (enterHdr),
        .byteValid_i (payloadByte),
        .rxByte_i    (RxData),
        .word_o      (asmWord),
        .wordFull_o  (wordFull)
    );

    // Next-state logic; every per-frame register is reloaded when a new load starts.
    always_comb begin
        state_d   = state_q;
        nWords_d  = nWords_q;
        wordCnt_d = wordCnt_q;
        xor_d     = xor_q;
        addr_d    = addr_q;
        enterHdr  = 1'b0;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (Start) begin
                    state_d   = HDR_HI;
                    enterHdr  = 1'b1;
                    nWords_d  = '0;
                    wordCnt_d = '0;
                    xor_d     = '0;
                    addr_d    = BASE_ADDR;
                end
            end
            HDR_HI: begin
                if (accept) begin
                    nWords_d[15:8] = RxData;
                    xor_d          = xor_q ^ RxData;
                    state_d        = HDR_LO;
                end
            end
            HDR_LO: begin
                if (accept) begin
                    nWords_d = headerN;
                    xor_d    = xor_q ^ RxData;
                    if (int'(headerN) > DEPTH_WORDS) begin
                        state_d = ERR;
                    end else if (headerN == 16'd0) begin
                        state_d = CHK;
                    end else begin
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    xor_d = xor_q ^ RxData;
                    if (wordFull) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                addr_d    = addr_q + 32'(WORD_BYTES);
                wordCnt_d = wordCnt_q + 16'd1;
                if (wordCnt_d == nWords_q) begin
                    state_d = CHK;
                end else begin
                    state_d = PAYLOAD;
                end
            end
            CHK: begin
                if (accept) begin
                    state_d = (RxData == xor_q) ? DONE : ERR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= IDLE;
            nWords_q  <= '0;
            wordCnt_q <= '0;
            xor_q     <= '0;
            addr_q    <= BASE_ADDR;
        end else begin
            state_q   <= state_d;
            nWords_q  <= nWords_d;
            wordCnt_q <= wordCnt_d;
            xor_q     <= xor_d;
            addr_q    <= addr_d;
        end
    end

    // Status is decoded from the state so it clears as soon as a new load begins.
    assign RxReady  = rxReadyFor(state_q);
    assign CpuHold  = cpuHoldFor(state_q);
    assign ImWrEn   = (state_q == WRITE);
    assign ImWrAddr = addr_q;
    assign ImWrData = asmWord;
    assign Done     = (state_q == DONE);
    assign Error    = (state_q == ERR);

endmodule

// File: tb/tb_im_program_loader.sv
// Scoreboard bench for im_program_loader: expected IM writes are queued as frames are sent
// and compared by a write monitor; status outputs are checked after each frame.
module tb_im_program_loader;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        Start = 1'b0;
    logic [7:0]  RxData = 8'h00;
    logic        RxValid = 1'b0;
    logic        RxReady;
    logic        ImWrEn;
    logic [31:0] ImWrAddr;
    logic [31:0] ImWrData;
    logic        CpuHold;
    logic        Done;
    logic        Error;

    int          checkCount = 0;
    int          errorCount = 0;
    logic [63:0] expQ[$];

    im_program_loader #(
        .DEPTH_WORDS (128),
        .BASE_ADDR   (32'h0000_0000)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Start    (Start),
        .RxData   (RxData),
        .RxValid  (RxValid),
        .RxReady  (RxReady),
        .ImWrEn   (ImWrEn),
        .ImWrAddr (ImWrAddr),
        .ImWrData (ImWrData),
        .CpuHold  (CpuHold),
        .Done     (Done),
        .Error    (Error)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Write monitor: every IM write must match the oldest queued expectation.
    always @(negedge Clk) begin
        if (ImWrEn === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_write", {ImWrAddr, ImWrData}, 64'hDEAD);
            end else begin
                checkOutput("write_addr_data", {ImWrAddr, ImWrData}, expQ.pop_front());
            end
            checkOutput("write_rxready", 64'(RxReady), 64'd0);
        end
    end

    // Presents one byte and waits (bounded) for the edge that accepts it; returns at a negedge.
    task automatic applyStimulus(input logic [7:0] b, input bit gap);
        bit accepted = 1'b0;
        RxData  = b;
        RxValid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (RxReady === 1'b1) begin
                @(posedge Clk);
                accepted = 1'b1;
                break;
            end
            @(posedge Clk);
            @(negedge Clk);
        end
        if (!accepted) begin
            checkOutput("byte_accept_timeout", 64'd0, 64'd1);
        end else begin
            @(negedge Clk);
        end
        if (gap) begin
            RxValid = 1'b0;
            @(negedge Clk);
        end
    endtask

    task automatic pulseStart();
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        checkOutput("start_cpuhold", 64'(CpuHold), 64'd1);
        checkOutput("start_rxready", 64'(RxReady), 64'd1);
    endtask

    task automatic sendSingle(input logic [7:0] chk);
        expQ.push_back({32'h0000_0000, 32'h2008_0005});
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h20, 1'b0);
        applyStimulus(8'h08, 1'b0);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h05, 1'b0);
        applyStimulus(chk, 1'b0);
        RxValid = 1'b0;
    endtask

    task automatic sendTwo(input bit gap);
        expQ.push_back({32'h0000_0000, 32'h8C09_0000});
        expQ.push_back({32'h0000_0004, 32'hAC09_0004});
        applyStimulus(8'h00, gap);
        applyStimulus(8'h02, gap);
        applyStimulus(8'h8C, gap);
        applyStimulus(8'h09, gap);
        applyStimulus(8'h00, gap);
        applyStimulus(8'h00, gap);
        applyStimulus(8'hAC, gap);
        applyStimulus(8'h09, gap);
        applyStimulus(8'h00, gap);
        applyStimulus(8'h04, gap);
        applyStimulus(8'h26, gap);
        RxValid = 1'b0;
    endtask

    task automatic checkStatus(input string tag, input logic done, input logic err, input logic hold);
        checkOutput({tag, "_done"}, 64'(Done), 64'(done));
        checkOutput({tag, "_error"}, 64'(Error), 64'(err));
        checkOutput({tag, "_cpuhold"}, 64'(CpuHold), 64'(hold));
        checkOutput({tag, "_pending_writes"}, 64'(expQ.size()), 64'd0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_rxready"}, 64'(RxReady), 64'd0);
        checkOutput({tag, "_wren"}, 64'(ImWrEn), 64'd0);
        checkOutput({tag, "_addr"}, 64'(ImWrAddr), 64'd0);
        checkOutput({tag, "_data"}, 64'(ImWrData), 64'd0);
        checkStatus(tag, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        Rst = 1'b1;
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        checkResetOutputs("reset");

        $display("[TB] single word frame");
        pulseStart();
        sendSingle(8'h2C);
        checkStatus("single", 1'b1, 1'b0, 1'b0);

        $display("[TB] two word frame");
        pulseStart();
        sendTwo(1'b0);
        checkStatus("two", 1'b1, 1'b0, 1'b0);

        $display("[TB] bad checksum then recovery");
        pulseStart();
        sendSingle(8'h2D);
        checkStatus("badchk", 1'b0, 1'b1, 1'b1);
        pulseStart();
        sendSingle(8'h2C);
        checkStatus("recover", 1'b1, 1'b0, 1'b0);

        $display("[TB] oversize header");
        pulseStart();
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h81, 1'b0);
        RxValid = 1'b0;
        checkStatus("oversize", 1'b0, 1'b1, 1'b1);
        checkOutput("oversize_rxready", 64'(RxReady), 64'd0);
        repeat (3) @(negedge Clk);
        checkOutput("oversize_still_err", 64'(Error), 64'd1);

        $display("[TB] reset mid-word");
        pulseStart();
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h20, 1'b0);
        applyStimulus(8'h08, 1'b0);
        RxValid = 1'b0;
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        checkResetOutputs("midreset");
        pulseStart();
        sendSingle(8'h2C);
        checkStatus("after_reset", 1'b1, 1'b0, 1'b0);

        $display("[TB] reset has priority over start");
        Rst = 1'b1;
        Start = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        Start = 1'b0;
        checkResetOutputs("rst_vs_start");

        $display("[TB] empty image");
        pulseStart();
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h00, 1'b0);
        RxValid = 1'b0;
        checkStatus("empty", 1'b1, 1'b0, 1'b0);

        $display("[TB] two word frame with gapped RxValid");
        pulseStart();
        sendTwo(1'b1);
        checkStatus("gapped", 1'b1, 1'b0, 1'b0);

        repeat (3) @(negedge Clk);
        checkOutput("final_pending_writes", 64'(expQ.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
